// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

    // Control FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } muldiv_state_e;

    // Operation select encoding on op_div.
    localparam logic MD_OP_MUL = 1'b0;
    localparam logic MD_OP_DIV = 1'b1;

    // Widest operand supported; the divide-by-zero quotient is sliced from this.
    localparam int MD_MAX_XLEN = 64;

    // Quotient returned for a divide by zero (all ones at any width).
    localparam logic [MD_MAX_XLEN-1:0] MD_DIV0_QUOT = {MD_MAX_XLEN{1'b1}};

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate: result = neg ? -value : value.
module muldiv_sign_fix #(
    parameter int W = 32
) (
    input  logic         neg,
    input  logic [W-1:0] value,
    output logic [W-1:0] result
);

    logic [W-1:0] one_s;

    assign one_s = {{(W-1){1'b0}}, 1'b1};

    // Select between the value and its two's complement.
    always_comb begin
        result = value;
        if (neg) begin
            result = ~value + one_s;
        end else begin
            result = value;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with valid/ready handshakes.
// Multiply: shift-add into a 2*XLEN accumulator. Divide: restoring
// shift-subtract. Results are HI/LO (product halves or remainder/quotient).
// Optional feature macro: MULDIV_EARLY_OUT_EN -- a divide with |op1| < |op2|
// and op2 != 0 skips the iteration and finishes in two cycles.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            op_div,
    input  logic            op_sign,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic            cancel,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_hi,
    output logic [XLEN-1:0] out_lo,
    output logic            out_div0
);

    muldiv_state_e     state_r;
    muldiv_state_e     state_nxt_s;

    logic [CNT_W-1:0]  cnt_r;
    logic [2*XLEN-1:0] acc_r;       // {hi, lo}: product or {remainder, dividend/quotient}
    logic [XLEN-1:0]   opb_r;       // multiplicand or divisor magnitude
    logic              is_div_r;
    logic              div0_r;
    logic              neg_lo_r;
    logic              neg_hi_r;
    logic              out_valid_r;
    logic [XLEN-1:0]   out_hi_r;
    logic [XLEN-1:0]   out_lo_r;
    logic              out_div0_r;

    logic              accept_s;
    logic              last_iter_s;
    logic              early_s;
    logic              s1_s;
    logic              s2_s;
    logic [XLEN-1:0]   mag1_s;
    logic [XLEN-1:0]   mag2_s;
    logic [XLEN:0]     mul_add_s;
    logic [XLEN:0]     mul_sum_s;
    logic [2*XLEN-1:0] mul_next_s;
    logic [XLEN:0]     div_shift_s;
    logic [XLEN:0]     div_diff_s;
    logic [2*XLEN-1:0] div_next_s;
    logic [XLEN-1:0]   res_hi_raw_s;
    logic [XLEN-1:0]   res_lo_raw_s;
    logic [XLEN-1:0]   hi_neg_s;
    logic [XLEN-1:0]   lo_fix_s;
    logic [XLEN-1:0]   hi_fix_s;
    logic [XLEN-1:0]   lo_res_s;

    assign in_ready    = (state_r == IDLE) & ~cancel;
    assign accept_s    = in_valid & in_ready;
    assign last_iter_s = (cnt_r == CNT_W'(XLEN - 1));

    assign out_valid   = out_valid_r;
    assign out_hi      = out_hi_r;
    assign out_lo      = out_lo_r;
    assign out_div0    = out_div0_r;

    // Operand magnitudes.
    assign s1_s = op_sign & op1[XLEN-1];
    assign s2_s = op_sign & op2[XLEN-1];

    muldiv_sign_fix #(.W(XLEN)) u_mag1 (.neg(s1_s), .value(op1), .result(mag1_s));
    muldiv_sign_fix #(.W(XLEN)) u_mag2 (.neg(s2_s), .value(op2), .result(mag2_s));

`ifdef MULDIV_EARLY_OUT_EN
    assign early_s = (op_div == MD_OP_DIV) & (|mag2_s) & (mag1_s < mag2_s);
`else
    assign early_s = 1'b0;
`endif

    // One multiply step: conditionally add the multiplicand, shift right.
    assign mul_add_s  = acc_r[0] ? {1'b0, opb_r} : {(XLEN+1){1'b0}};
    assign mul_sum_s  = {1'b0, acc_r[2*XLEN-1:XLEN]} + mul_add_s;
    assign mul_next_s = {mul_sum_s, acc_r[XLEN-1:1]};

    // One restoring divide step: shift in the next dividend bit, try subtract.
    assign div_shift_s = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]};
    assign div_diff_s  = div_shift_s - {1'b0, opb_r};
    assign div_next_s  = div_diff_s[XLEN]
                       ? {div_shift_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0}
                       : {div_diff_s[XLEN-1:0],  acc_r[XLEN-2:0], 1'b1};

    // Result sign correction.
    assign res_hi_raw_s = acc_r[2*XLEN-1:XLEN];
    assign res_lo_raw_s = acc_r[XLEN-1:0];

    muldiv_sign_fix #(.W(XLEN)) u_fix_lo (.neg(neg_lo_r), .value(res_lo_raw_s), .result(lo_fix_s));
    muldiv_sign_fix #(.W(XLEN)) u_fix_hi (.neg(neg_hi_r), .value(res_hi_raw_s), .result(hi_neg_s));

    // Product high half: the +1 of a 2*XLEN negate only carries into HI when LO is zero.
    always_comb begin
        hi_fix_s = hi_neg_s;
        if (!is_div_r && neg_hi_r && (|res_lo_raw_s)) begin
            hi_fix_s = ~res_hi_raw_s;
        end else begin
            hi_fix_s = hi_neg_s;
        end
    end

    // LO result: divide by zero forces the all-ones quotient.
    always_comb begin
        lo_res_s = lo_fix_s;
        if (is_div_r && div0_r) begin
            lo_res_s = MD_DIV0_QUOT[XLEN-1:0];
        end else begin
            lo_res_s = lo_fix_s;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; cancel returns to IDLE from anywhere.
    always_comb begin
        state_nxt_s = state_r;
        if (cancel) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_nxt_s = early_s ? FIX : BUSY;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                BUSY: begin
                    if (last_iter_s) begin
                        state_nxt_s = FIX;
                    end else begin
                        state_nxt_s = BUSY;
                    end
                end
                FIX: begin
                    state_nxt_s = DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = DONE;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

    // Datapath: operand capture, iteration, result registration.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_r       <= {CNT_W{1'b0}};
            acc_r       <= {(2*XLEN){1'b0}};
            opb_r       <= {XLEN{1'b0}};
            is_div_r    <= 1'b0;
            div0_r      <= 1'b0;
            neg_lo_r    <= 1'b0;
            neg_hi_r    <= 1'b0;
            out_valid_r <= 1'b0;
            out_hi_r    <= {XLEN{1'b0}};
            out_lo_r    <= {XLEN{1'b0}};
            out_div0_r  <= 1'b0;
        end else if (cancel) begin
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        cnt_r    <= {CNT_W{1'b0}};
                        is_div_r <= op_div;
                        div0_r   <= (op_div == MD_OP_DIV) & ~(|op2);
                        neg_lo_r <= s1_s ^ s2_s;
                        neg_hi_r <= (op_div == MD_OP_DIV) ? s1_s : (s1_s ^ s2_s);
                        opb_r    <= (op_div == MD_OP_MUL) ? mag1_s : mag2_s;
                        if (early_s) begin
                            acc_r <= {mag1_s, {XLEN{1'b0}}};
                        end else if (op_div == MD_OP_MUL) begin
                            acc_r <= {{XLEN{1'b0}}, mag2_s};
                        end else begin
                            acc_r <= {{XLEN{1'b0}}, mag1_s};
                        end
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                BUSY: begin
                    cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    acc_r <= is_div_r ? div_next_s : mul_next_s;
                end
                FIX: begin
                    out_hi_r    <= hi_fix_s;
                    out_lo_r    <= lo_res_s;
                    out_div0_r  <= is_div_r & div0_r;
                    out_valid_r <= 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule
